biriscv_exec_stage: RTL and testbench
=====================================

BIRISCV_EXEC_STAGE -- requirements
Module: biriscv_exec_stage

Interface
REQ-001 SHALL have port clk_i  input  1  sole clock; all state updates on its rising edge.
REQ-002 SHALL have port rst_ni  input  1  reset, synchronous, active-low.
REQ-003 SHALL have port opcode_valid_i  input  1  an issued instruction is present this cycle.
REQ-004 SHALL have port opcode_opcode_i  input  32  raw RV32I instruction word.
REQ-005 SHALL have port opcode_pc_i  input  32  PC of the instruction.
REQ-006 SHALL have port opcode_ra_operand_i / opcode_rb_operand_i  input  32 each  rs1 / rs2 values.
REQ-007 SHALL have port hold_i  input  1  downstream stall; freezes the output stage.
REQ-008 SHALL have port squash_i  input  1  pipeline flush; kills the instruction being registered.
REQ-009 SHALL have port writeback_valid_o  output  1  registered result is valid for the register file.
REQ-010 SHALL have port writeback_rd_o  output  5  destination register index.
REQ-011 SHALL have port writeback_value_o  output  32  result value.
REQ-012 SHALL have port branch_request_o  output  1  control-transfer instruction resolved.
REQ-013 SHALL have port branch_is_taken_o  output  1  transfer taken.
REQ-014 SHALL have port branch_pc_o  output  32  target PC when taken, else PC+4.

Function
REQ-015 SHALL decode OP, OP-IMM, LUI, AUIPC, JAL, JALR and BRANCH (BEQ/BNE/BLT/BGE/BLTU/BGEU) and select the ALU op and operands A/B.
REQ-016 SHALL use rs1 and sign-extended I-immediate for OP-IMM; shamt = imm[4:0]; SRAI selected by instr[30].
REQ-017 SHALL compute LUI as {imm[31:12],12'b0}; AUIPC as PC + that value; JAL/JALR result as PC+4.
REQ-018 SHALL compute JAL target PC + J-immediate; JALR target (rs1 + I-immediate) with bit 0 cleared; BRANCH target PC + B-immediate; all 32-bit wrap-around.
REQ-019 SHALL evaluate branch conditions from the ALU subtract / compare results, signed and unsigned per funct3.
REQ-020 SHALL have a latency of exactly one cycle: inputs sampled at edge N appear on outputs after edge N.
REQ-021 SHALL, when hold_i=1 and squash_i=0, retain all output registers unchanged.
REQ-022 SHALL, when squash_i=1, clear writeback_valid_o and branch_request_o at the next edge regardless of hold_i (squash wins).
REQ-023 SHALL drive writeback_valid_o=0 for undecoded opcodes, for BRANCH, and when rd=0; value/rd registers still load.
REQ-024 SHALL drive branch_request_o=1 only for JAL, JALR and BRANCH with opcode_valid_i=1.
REQ-025 SHALL register a bubble (valid outputs 0) when opcode_valid_i=0 and hold_i=0.

Reset
REQ-026 SHALL, on rst_ni=0 at a clock edge, set every output to 0, overriding hold_i and squash_i.
REQ-027 SHALL discard any instruction presented in a reset cycle; first valid result appears one cycle after the first non-reset sampling edge.

Structure
REQ-028 SHALL take ALU op encodings and RV32I opcode/funct constants from the shared biriscv_defs package; no local duplicates.
REQ-029 SHALL instantiate exactly one biriscv_alu sub-module for all ALU arithmetic, logic, shift and compare operations; branch target adders are local.
REQ-030 SHALL keep decode combinational and all state in a single output register stage.

Verification
REQ-031 SHALL check ADDI x1,x0,-3 with rs1=5 -> next cycle valid=1, rd=1, value=0x00000002.
REQ-032 SHALL check SRAI x2,x3,4 with rs1=0x80000000 -> value=0xF8000000; SRLI same -> 0x08000000.
REQ-033 SHALL check BEQ at PC=0x100, imm=+0x20, rs1=rs2=7 -> branch_request=1, taken=1, branch_pc=0x120, writeback_valid=0; rs2=8 -> taken=0, branch_pc=0x104.
REQ-034 SHALL check JALR x1 at PC=0x200, rs1=0x1001, imm=0 -> branch_pc=0x1000, value=0x204, rd=1.
REQ-035 SHALL check hold_i=1 for 3 cycles after an ADD -> outputs stable; then hold_i=1 with squash_i=1 -> valid outputs 0 next cycle.
REQ-036 SHALL check rst_ni=0 asserted while a valid ADD is registered -> all outputs 0 next cycle; no result emerges after release.

Source files
------------

// File: rtl/biriscv_defs.sv
// Shared RV32I opcode/funct constants, ALU op encodings and
// the execute-stage result bundle.
package biriscv_defs;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef enum logic [3:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_XOR,
        ALU_SLL,
        ALU_SRL,
        ALU_SRA,
        ALU_SLT,
        ALU_SLTU
    } alu_op_e;

    typedef struct packed {
        logic        wb_valid;
        logic [4:0]  rd;
        logic [31:0] value;
        logic        br_request;
        logic        br_taken;
        logic [31:0] br_pc;
    } ex_wb_t;

    // funct3 values 010/011 are reserved in the BRANCH space.
    function automatic logic br_f3_ok(input logic [2:0] f3);
        return (f3 != 3'b010) && (f3 != 3'b011);
    endfunction

endpackage

// File: rtl/biriscv_exec_stage_if.sv
// Issue/result bundle of the execute stage: the issuing side is
// the master, the execute stage is the slave.
interface biriscv_exec_stage_if;

    logic        valid;
    logic [31:0] opcode;
    logic [31:0] pc;
    logic [31:0] ra_operand;
    logic [31:0] rb_operand;
    logic        hold;
    logic        squash;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_value;
    logic        br_request;
    logic        br_taken;
    logic [31:0] br_pc;

    modport master (
        output valid, opcode, pc, ra_operand, rb_operand,
        output hold, squash,
        input  wb_valid, wb_rd, wb_value,
        input  br_request, br_taken, br_pc
    );

    modport slave (
        input  valid, opcode, pc, ra_operand, rb_operand,
        input  hold, squash,
        output wb_valid, wb_rd, wb_value,
        output br_request, br_taken, br_pc
    );

endinterface

// File: rtl/biriscv_alu.sv
// Single-cycle RV32I ALU; also exports compare flags derived from
// one 33-bit subtract so the branch unit shares the same datapath.
module biriscv_alu
    import biriscv_defs::*;
(
    input  alu_op_e     op_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic [31:0] result_o,
    output logic        eq_o,
    output logic        lt_o,
    output logic        ltu_o
);

    logic [32:0] diff;

    assign diff  = {1'b0, a_i} - {1'b0, b_i};
    assign eq_o  = (diff[31:0] == 32'd0);
    assign ltu_o = diff[32];
    // Differing signs decide directly; otherwise the difference sign does.
    assign lt_o  = (a_i[31] != b_i[31]) ? a_i[31] : diff[31];

    always_comb begin
        result_o = 32'd0;
        unique case (op_i)
            ALU_ADD:  result_o = a_i + b_i;
            ALU_SUB:  result_o = diff[31:0];
            ALU_AND:  result_o = a_i & b_i;
            ALU_OR:   result_o = a_i | b_i;
            ALU_XOR:  result_o = a_i ^ b_i;
            ALU_SLL:  result_o = a_i << b_i[4:0];
            ALU_SRL:  result_o = a_i >> b_i[4:0];
            ALU_SRA:  result_o = $signed(a_i) >>> b_i[4:0];
            ALU_SLT:  result_o = {31'd0, lt_o};
            ALU_SLTU: result_o = {31'd0, ltu_o};
            default:  result_o = 32'd0;
        endcase
    end

endmodule

// File: rtl/biriscv_exec_stage.sv
// RV32I execute stage: combinational decode and ALU feeding one
// output register holding the writeback and branch-resolution results.
module biriscv_exec_stage
    import biriscv_defs::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        opcode_valid_i,
    input  logic [31:0] opcode_opcode_i,
    input  logic [31:0] opcode_pc_i,
    input  logic [31:0] opcode_ra_operand_i,
    input  logic [31:0] opcode_rb_operand_i,
    input  logic        hold_i,
    input  logic        squash_i,
    output logic        writeback_valid_o,
    output logic [4:0]  writeback_rd_o,
    output logic [31:0] writeback_value_o,
    output logic        branch_request_o,
    output logic        branch_is_taken_o,
    output logic [31:0] branch_pc_o
);

    logic [6:0]  opc;
    logic [2:0]  funct3;
    logic [4:0]  rd;
    logic        alt;
    logic [31:0] imm_i;
    logic [31:0] imm_u;
    logic [31:0] imm_b;
    logic [31:0] imm_j;

    assign opc    = opcode_opcode_i[6:0];
    assign funct3 = opcode_opcode_i[14:12];
    assign rd     = opcode_opcode_i[11:7];
    assign alt    = opcode_opcode_i[30];

    assign imm_i = {{20{opcode_opcode_i[31]}},
                    opcode_opcode_i[31:20]};
    assign imm_u = {opcode_opcode_i[31:12], 12'd0};
    assign imm_b = {{19{opcode_opcode_i[31]}},
                    opcode_opcode_i[31],
                    opcode_opcode_i[7],
                    opcode_opcode_i[30:25],
                    opcode_opcode_i[11:8], 1'b0};
    assign imm_j = {{11{opcode_opcode_i[31]}},
                    opcode_opcode_i[31],
                    opcode_opcode_i[19:12],
                    opcode_opcode_i[20],
                    opcode_opcode_i[30:21], 1'b0};

    logic [31:0] pc_plus4;
    logic [31:0] jal_tgt;
    logic [31:0] jalr_sum;
    logic [31:0] jalr_tgt;
    logic [31:0] br_tgt;

    assign pc_plus4 = opcode_pc_i + 32'd4;
    assign jal_tgt  = opcode_pc_i + imm_j;
    assign jalr_sum = opcode_ra_operand_i + imm_i;
    assign jalr_tgt = {jalr_sum[31:1], 1'b0};
    assign br_tgt   = opcode_pc_i + imm_b;

    alu_op_e     alu_op;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [31:0] alu_res;
    logic        alu_eq;
    logic        alu_lt;
    logic        alu_ltu;
    logic        wb_en;
    logic        is_jump;
    logic        is_br;
    logic [31:0] xfer_tgt;

    always_comb begin
        alu_op   = ALU_ADD;
        alu_a    = opcode_ra_operand_i;
        alu_b    = opcode_rb_operand_i;
        wb_en    = 1'b0;
        is_jump  = 1'b0;
        is_br    = 1'b0;
        xfer_tgt = br_tgt;
        unique case (1'b1)
            (opc == OPC_OP): begin
                wb_en = 1'b1;
                case (funct3)
                    F3_ADD:  alu_op = alt ? ALU_SUB : ALU_ADD;
                    F3_SLL:  alu_op = ALU_SLL;
                    F3_SLT:  alu_op = ALU_SLT;
                    F3_SLTU: alu_op = ALU_SLTU;
                    F3_XOR:  alu_op = ALU_XOR;
                    F3_SR:   alu_op = alt ? ALU_SRA : ALU_SRL;
                    F3_OR:   alu_op = ALU_OR;
                    default: alu_op = ALU_AND;
                endcase
            end
            (opc == OPC_OP_IMM): begin
                wb_en = 1'b1;
                alu_b = imm_i;
                case (funct3)
                    F3_ADD:  alu_op = ALU_ADD;
                    F3_SLL:  alu_op = ALU_SLL;
                    F3_SLT:  alu_op = ALU_SLT;
                    F3_SLTU: alu_op = ALU_SLTU;
                    F3_XOR:  alu_op = ALU_XOR;
                    F3_SR:   alu_op = alt ? ALU_SRA : ALU_SRL;
                    F3_OR:   alu_op = ALU_OR;
                    default: alu_op = ALU_AND;
                endcase
            end
            (opc == OPC_LUI): begin
                wb_en = 1'b1;
                alu_a = 32'd0;
                alu_b = imm_u;
            end
            (opc == OPC_AUIPC): begin
                wb_en = 1'b1;
                alu_a = opcode_pc_i;
                alu_b = imm_u;
            end
            (opc == OPC_JAL): begin
                wb_en    = 1'b1;
                is_jump  = 1'b1;
                alu_a    = opcode_pc_i;
                alu_b    = 32'd4;
                xfer_tgt = jal_tgt;
            end
            (opc == OPC_JALR): begin
                wb_en    = 1'b1;
                is_jump  = 1'b1;
                alu_a    = opcode_pc_i;
                alu_b    = 32'd4;
                xfer_tgt = jalr_tgt;
            end
            (opc == OPC_BRANCH): begin
                alu_op = ALU_SUB;
                is_br  = br_f3_ok(funct3);
            end
            default: ;
        endcase
    end

    biriscv_alu u_alu (
        .op_i     (alu_op),
        .a_i      (alu_a),
        .b_i      (alu_b),
        .result_o (alu_res),
        .eq_o     (alu_eq),
        .lt_o     (alu_lt),
        .ltu_o    (alu_ltu)
    );

    logic br_cond;
    logic take;

    always_comb begin
        br_cond = 1'b0;
        case (funct3)
            F3_BEQ:  br_cond = alu_eq;
            F3_BNE:  br_cond = !alu_eq;
            F3_BLT:  br_cond = alu_lt;
            F3_BGE:  br_cond = !alu_lt;
            F3_BLTU: br_cond = alu_ltu;
            F3_BGEU: br_cond = !alu_ltu;
            default: br_cond = 1'b0;
        endcase
    end

    assign take = is_jump | (is_br & br_cond);

    ex_wb_t d;
    ex_wb_t q;

    always_comb begin
        d            = '0;
        d.wb_valid   = opcode_valid_i & wb_en & (rd != 5'd0);
        d.rd         = rd;
        d.value      = alu_res;
        d.br_request = opcode_valid_i & (is_jump | is_br);
        d.br_taken   = opcode_valid_i & take;
        d.br_pc      = take ? xfer_tgt : pc_plus4;
    end

    // Squash only kills the valid flags; data registers keep their contents.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            q <= '0;
        end else if (squash_i) begin
            q.wb_valid   <= 1'b0;
            q.br_request <= 1'b0;
        end else if (!hold_i) begin
            q <= d;
        end
    end

    assign writeback_valid_o = q.wb_valid;
    assign writeback_rd_o    = q.rd;
    assign writeback_value_o = q.value;
    assign branch_request_o  = q.br_request;
    assign branch_is_taken_o = q.br_taken;
    assign branch_pc_o       = q.br_pc;

endmodule

// File: tb/tb_biriscv_exec_stage.sv
// Scoreboard bench for biriscv_exec_stage: each issued vector pushes
// its expected registered outputs, compared one cycle later.
module tb_biriscv_exec_stage;

    logic clk = 1'b0;
    logic rst_ni = 1'b0;

    biriscv_exec_stage_if bus ();

    biriscv_exec_stage dut (
        .clk_i               (clk),
        .rst_ni              (rst_ni),
        .opcode_valid_i      (bus.valid),
        .opcode_opcode_i     (bus.opcode),
        .opcode_pc_i         (bus.pc),
        .opcode_ra_operand_i (bus.ra_operand),
        .opcode_rb_operand_i (bus.rb_operand),
        .hold_i              (bus.hold),
        .squash_i            (bus.squash),
        .writeback_valid_o   (bus.wb_valid),
        .writeback_rd_o      (bus.wb_rd),
        .writeback_value_o   (bus.wb_value),
        .branch_request_o    (bus.br_request),
        .branch_is_taken_o   (bus.br_taken),
        .branch_pc_o         (bus.br_pc)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        wv;
        logic [4:0]  rd;
        logic [31:0] val;
        logic        br;
        logic        tk;
        logic [31:0] bpc;
    } obs_t;

    typedef struct {
        string       nm;
        logic        vld;
        logic [31:0] ins;
        logic [31:0] pc;
        logic [31:0] ra;
        logic [31:0] rb;
        obs_t        e;
        obs_t        m;
    } vec_t;

    typedef struct {
        string nm;
        obs_t  e;
        obs_t  m;
    } sb_t;

    localparam obs_t M_ALL = '1;
    localparam obs_t M_BR = '{wv: 1'b1, rd: 5'd0, val: 32'd0,
                              br: 1'b1, tk: 1'b1, bpc: 32'hFFFF_FFFF};
    localparam obs_t M_FLAGS = '{wv: 1'b1, rd: 5'd0, val: 32'd0,
                                 br: 1'b1, tk: 1'b0, bpc: 32'd0};

    int   n_cmp = 0;
    int   n_err = 0;
    sb_t  sb_q[$];

    function automatic logic [31:0] enc_i(input logic [11:0] imm,
        input logic [4:0] rs1, input logic [2:0] f3,
        input logic [4:0] rd, input logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] enc_r(input logic [6:0] f7,
        input logic [2:0] f3, input logic [4:0] rd);
        return {f7, 5'd2, 5'd1, f3, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] enc_b(input logic [12:0] imm,
        input logic [2:0] f3);
        return {imm[12], imm[10:5], 5'd2, 5'd1, f3,
                imm[4:1], imm[11], 7'b1100011};
    endfunction

    function automatic logic [31:0] enc_j(input logic [20:0] imm,
        input logic [4:0] rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
    endfunction

    function automatic logic [31:0] enc_u(input logic [19:0] imm,
        input logic [4:0] rd, input logic [6:0] op);
        return {imm, rd, op};
    endfunction

    function automatic obs_t wbx(input logic [4:0] rd,
        input logic [31:0] val, input logic [31:0] pc);
        return '{wv: (rd != 5'd0), rd: rd, val: val,
                 br: 1'b0, tk: 1'b0, bpc: pc + 32'd4};
    endfunction

    function automatic obs_t brx(input logic tk, input logic [31:0] bpc);
        return '{wv: 1'b0, rd: 5'd0, val: 32'd0,
                 br: 1'b1, tk: tk, bpc: bpc};
    endfunction

    function automatic obs_t jx(input logic [4:0] rd,
        input logic [31:0] val, input logic [31:0] bpc);
        return '{wv: (rd != 5'd0), rd: rd, val: val,
                 br: 1'b1, tk: 1'b1, bpc: bpc};
    endfunction

    function automatic vec_t mkv(input string nm, input logic vld,
        input logic [31:0] ins, input logic [31:0] pc,
        input logic [31:0] ra, input logic [31:0] rb,
        input obs_t e, input obs_t m);
        vec_t v;
        v.nm = nm; v.vld = vld; v.ins = ins; v.pc = pc;
        v.ra = ra; v.rb = rb; v.e = e; v.m = m;
        return v;
    endfunction

    function automatic obs_t cur();
        return '{wv: bus.wb_valid, rd: bus.wb_rd, val: bus.wb_value,
                 br: bus.br_request, tk: bus.br_taken, bpc: bus.br_pc};
    endfunction

    task automatic apply(input vec_t v);
        sb_t s;
        bus.valid      = v.vld;
        bus.opcode     = v.ins;
        bus.pc         = v.pc;
        bus.ra_operand = v.ra;
        bus.rb_operand = v.rb;
        s.nm = v.nm; s.e = v.e; s.m = v.m;
        sb_q.push_back(s);
        @(posedge clk);
        #1;
    endtask

    vec_t add7;
    vec_t jal1;

    task automatic test_reset();
        vec_t v[$];
        sb_t  s;
        obs_t got;
        v.push_back(mkv("rst_hold_squash", 1'b1, add7.ins, 32'h40,
                        32'd3, 32'd4, '0, M_ALL));
        v.push_back(mkv("rst_plain", 1'b1, add7.ins, 32'h40,
                        32'd3, 32'd4, '0, M_ALL));
        v.push_back(mkv("rst_release_bubble", 1'b0, add7.ins, 32'h40,
                        32'd3, 32'd4, '0, M_FLAGS));
        v.push_back(add7);
        foreach (v[i]) begin
            rst_ni     = (i >= 2);
            bus.hold   = (i == 0);
            bus.squash = (i == 0);
            apply(v[i]);
            s = sb_q.pop_front();
            got = cur();
            n_cmp++;
            if ((got & s.m) !== (s.e & s.m)) begin
                n_err++;
                $display("FAIL %s: got %h want %h", s.nm,
                         got & s.m, s.e & s.m);
            end
        end
    endtask

    task automatic test_alu();
        vec_t v[$];
        sb_t  s;
        obs_t got;
        v.push_back(mkv("addi_neg", 1'b1,
            enc_i(12'hFFD, 5'd0, 3'b000, 5'd1, 7'h13), 32'h80,
            32'd5, 32'd0, wbx(5'd1, 32'h2, 32'h80), M_ALL));
        v.push_back(mkv("srai", 1'b1,
            enc_i(12'h404, 5'd3, 3'b101, 5'd2, 7'h13), 32'h80,
            32'h8000_0000, 32'd0, wbx(5'd2, 32'hF800_0000, 32'h80), M_ALL));
        v.push_back(mkv("srli", 1'b1,
            enc_i(12'h004, 5'd3, 3'b101, 5'd2, 7'h13), 32'h80,
            32'h8000_0000, 32'd0, wbx(5'd2, 32'h0800_0000, 32'h80), M_ALL));
        v.push_back(mkv("add", 1'b1, enc_r(7'h00, 3'b000, 5'd5), 32'h80,
            32'd10, 32'd3, wbx(5'd5, 32'd13, 32'h80), M_ALL));
        v.push_back(mkv("sub", 1'b1, enc_r(7'h20, 3'b000, 5'd5), 32'h80,
            32'd10, 32'd3, wbx(5'd5, 32'd7, 32'h80), M_ALL));
        v.push_back(mkv("slt", 1'b1, enc_r(7'h00, 3'b010, 5'd6), 32'h80,
            32'hFFFF_FFFF, 32'd1, wbx(5'd6, 32'd1, 32'h80), M_ALL));
        v.push_back(mkv("sltu", 1'b1, enc_r(7'h00, 3'b011, 5'd6), 32'h80,
            32'hFFFF_FFFF, 32'd1, wbx(5'd6, 32'd0, 32'h80), M_ALL));
        v.push_back(mkv("xor", 1'b1, enc_r(7'h00, 3'b100, 5'd8), 32'h80,
            32'hF0F0, 32'hFF00, wbx(5'd8, 32'h0FF0, 32'h80), M_ALL));
        v.push_back(mkv("or", 1'b1, enc_r(7'h00, 3'b110, 5'd8), 32'h80,
            32'hF0F0, 32'hFF00, wbx(5'd8, 32'hFFF0, 32'h80), M_ALL));
        v.push_back(mkv("and", 1'b1, enc_r(7'h00, 3'b111, 5'd8), 32'h80,
            32'hF0F0, 32'hFF00, wbx(5'd8, 32'hF000, 32'h80), M_ALL));
        v.push_back(mkv("sll_shamt5", 1'b1, enc_r(7'h00, 3'b001, 5'd9),
            32'h80, 32'd1, 32'd33, wbx(5'd9, 32'd2, 32'h80), M_ALL));
        v.push_back(mkv("sltiu", 1'b1,
            enc_i(12'h005, 5'd1, 3'b011, 5'd7, 7'h13), 32'h80,
            32'd3, 32'd0, wbx(5'd7, 32'd1, 32'h80), M_ALL));
        v.push_back(mkv("andi_sext", 1'b1,
            enc_i(12'hF0F, 5'd1, 3'b111, 5'd7, 7'h13), 32'h80,
            32'hFF, 32'd0, wbx(5'd7, 32'h0F, 32'h80), M_ALL));
        v.push_back(mkv("lui", 1'b1, enc_u(20'h12345, 5'd3, 7'h37),
            32'h80, 32'd9, 32'd9, wbx(5'd3, 32'h1234_5000, 32'h80), M_ALL));
        v.push_back(mkv("auipc", 1'b1, enc_u(20'h00001, 5'd4, 7'h17),
            32'h1000, 32'd0, 32'd0, wbx(5'd4, 32'h2000, 32'h1000), M_ALL));
        v.push_back(mkv("add_x0", 1'b1, enc_r(7'h00, 3'b000, 5'd0),
            32'h80, 32'd1, 32'd2, wbx(5'd0, 32'd3, 32'h80), M_ALL));
        foreach (v[i]) begin
            apply(v[i]);
            s = sb_q.pop_front();
            got = cur();
            n_cmp++;
            if ((got & s.m) !== (s.e & s.m)) begin
                n_err++;
                $display("FAIL %s: got %h want %h", s.nm,
                         got & s.m, s.e & s.m);
            end
        end
    endtask

    task automatic test_branch();
        vec_t v[$];
        sb_t  s;
        obs_t got;
        v.push_back(mkv("beq_taken", 1'b1, enc_b(13'h020, 3'b000),
            32'h100, 32'd7, 32'd7, brx(1'b1, 32'h120), M_BR));
        v.push_back(mkv("beq_not", 1'b1, enc_b(13'h020, 3'b000),
            32'h100, 32'd7, 32'd8, brx(1'b0, 32'h104), M_BR));
        v.push_back(mkv("bne_taken", 1'b1, enc_b(13'h020, 3'b001),
            32'h100, 32'd7, 32'd8, brx(1'b1, 32'h120), M_BR));
        v.push_back(mkv("blt_taken", 1'b1, enc_b(13'h020, 3'b100),
            32'h100, 32'hFFFF_FFFF, 32'd1, brx(1'b1, 32'h120), M_BR));
        v.push_back(mkv("bltu_not", 1'b1, enc_b(13'h020, 3'b110),
            32'h100, 32'hFFFF_FFFF, 32'd1, brx(1'b0, 32'h104), M_BR));
        v.push_back(mkv("bge_taken", 1'b1, enc_b(13'h020, 3'b101),
            32'h100, 32'd1, 32'hFFFF_FFFF, brx(1'b1, 32'h120), M_BR));
        v.push_back(mkv("bgeu_equal", 1'b1, enc_b(13'h020, 3'b111),
            32'h100, 32'd5, 32'd5, brx(1'b1, 32'h120), M_BR));
        v.push_back(mkv("beq_back", 1'b1, enc_b(13'h1FF0, 3'b000),
            32'h100, 32'd3, 32'd3, brx(1'b1, 32'hF0), M_BR));
        foreach (v[i]) begin
            apply(v[i]);
            s = sb_q.pop_front();
            got = cur();
            n_cmp++;
            if ((got & s.m) !== (s.e & s.m)) begin
                n_err++;
                $display("FAIL %s: got %h want %h", s.nm,
                         got & s.m, s.e & s.m);
            end
        end
    endtask

    task automatic test_jump();
        vec_t v[$];
        sb_t  s;
        obs_t got;
        v.push_back(mkv("jalr_bit0", 1'b1,
            enc_i(12'h000, 5'd5, 3'b000, 5'd1, 7'h67), 32'h200,
            32'h1001, 32'd0, jx(5'd1, 32'h204, 32'h1000), M_ALL));
        v.push_back(mkv("jalr_neg", 1'b1,
            enc_i(12'hFFC, 5'd5, 3'b000, 5'd1, 7'h67), 32'h10,
            32'h2000, 32'd0, jx(5'd1, 32'h14, 32'h1FFC), M_ALL));
        v.push_back(jal1);
        v.push_back(mkv("jal_x0_back", 1'b1, enc_j(21'h1FFFF8, 5'd0),
            32'h40, 32'd0, 32'd0, jx(5'd0, 32'h44, 32'h38), M_ALL));
        v.push_back(mkv("jal_wrap", 1'b1, enc_j(21'h000008, 5'd1),
            32'hFFFF_FFFC, 32'd0, 32'd0, jx(5'd1, 32'h0, 32'h4), M_ALL));
        foreach (v[i]) begin
            apply(v[i]);
            s = sb_q.pop_front();
            got = cur();
            n_cmp++;
            if ((got & s.m) !== (s.e & s.m)) begin
                n_err++;
                $display("FAIL %s: got %h want %h", s.nm,
                         got & s.m, s.e & s.m);
            end
        end
    endtask

    task automatic test_bubble();
        vec_t v[$];
        sb_t  s;
        obs_t got;
        v.push_back(mkv("undecoded", 1'b1, 32'h0000_007F, 32'h80,
            32'd1, 32'd1, '0, M_FLAGS));
        v.push_back(mkv("bubble_add", 1'b0, add7.ins, 32'h80,
            32'd1, 32'd1, '0, M_FLAGS));
        v.push_back(mkv("bubble_jal", 1'b0, jal1.ins, 32'h300,
            32'd0, 32'd0, '0, M_FLAGS));
        v.push_back(mkv("branch_bad_f3", 1'b1, enc_b(13'h020, 3'b010),
            32'h100, 32'd1, 32'd1, '0, M_FLAGS));
        foreach (v[i]) begin
            apply(v[i]);
            s = sb_q.pop_front();
            got = cur();
            n_cmp++;
            if ((got & s.m) !== (s.e & s.m)) begin
                n_err++;
                $display("FAIL %s: got %h want %h", s.nm,
                         got & s.m, s.e & s.m);
            end
        end
    endtask

    task automatic test_hold_squash();
        vec_t v[$];
        vec_t h;
        sb_t  s;
        obs_t got;
        logic hd[$];
        logic sq[$];
        h = jal1;
        h.nm = "hold_stable";
        h.e = add7.e;
        v.push_back(add7);  hd.push_back(0); sq.push_back(0);
        for (int k = 0; k < 3; k++) begin
            v.push_back(h); hd.push_back(1); sq.push_back(0);
        end
        v.push_back(jal1);  hd.push_back(0); sq.push_back(0);
        h = add7; h.nm = "squash_over_hold"; h.e = '0; h.m = M_FLAGS;
        v.push_back(h);     hd.push_back(1); sq.push_back(1);
        h.nm = "squash_no_hold";
        v.push_back(h);     hd.push_back(0); sq.push_back(1);
        v.push_back(add7);  hd.push_back(0); sq.push_back(0);
        foreach (v[i]) begin
            bus.hold   = hd[i];
            bus.squash = sq[i];
            apply(v[i]);
            s = sb_q.pop_front();
            got = cur();
            n_cmp++;
            if ((got & s.m) !== (s.e & s.m)) begin
                n_err++;
                $display("FAIL %s: got %h want %h", s.nm,
                         got & s.m, s.e & s.m);
            end
        end
        bus.hold   = 1'b0;
        bus.squash = 1'b0;
    endtask

    task automatic test_reset_mid();
        vec_t v[$];
        sb_t  s;
        obs_t got;
        v.push_back(add7);
        v.push_back(mkv("rst_mid", 1'b1, add7.ins, 32'h40,
            32'd3, 32'd4, '0, M_ALL));
        v.push_back(mkv("rst_after_1", 1'b0, add7.ins, 32'h40,
            32'd3, 32'd4, '0, M_FLAGS));
        v.push_back(mkv("rst_after_2", 1'b0, add7.ins, 32'h40,
            32'd3, 32'd4, '0, M_FLAGS));
        foreach (v[i]) begin
            rst_ni = (i != 1);
            apply(v[i]);
            s = sb_q.pop_front();
            got = cur();
            n_cmp++;
            if ((got & s.m) !== (s.e & s.m)) begin
                n_err++;
                $display("FAIL %s: got %h want %h", s.nm,
                         got & s.m, s.e & s.m);
            end
        end
        rst_ni = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.valid      = 1'b0;
        bus.opcode     = 32'd0;
        bus.pc         = 32'd0;
        bus.ra_operand = 32'd0;
        bus.rb_operand = 32'd0;
        bus.hold       = 1'b0;
        bus.squash     = 1'b0;
        add7 = mkv("add_x7", 1'b1, enc_r(7'h00, 3'b000, 5'd7), 32'h40,
                   32'd3, 32'd4, wbx(5'd7, 32'd7, 32'h40), M_ALL);
        jal1 = mkv("jal_fwd", 1'b1, enc_j(21'h000800, 5'd5), 32'h300,
                   32'd0, 32'd0, jx(5'd5, 32'h304, 32'hB00), M_ALL);
        @(negedge clk);
        test_reset();
        test_alu();
        test_branch();
        test_jump();
        test_bubble();
        test_hold_squash();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
